shift_deser: RTL

Serial-to-parallel receiver, the counterpart of the team's 8-bit parallel-load, MSB-first shift transmitter. It samples one bit per enabled clock and assembles WIDTH-bit words MSB first. Each completed word is presented on a valid/ready output port with a single holding register. A sticky overrun flag reports words lost to backpressure. The block sits on the receive end of the serial link, between the bit source (transmitter output or LFSR stream) and the byte consumer.

---
 rtl/shift_deser_pkg.sv | 16 +
 rtl/deser_hold_reg.sv | 51 +++++
 rtl/shift_deser.sv | 62 ++++++
 3 files changed

// File: rtl/shift_deser_pkg.sv
// Shared constants for the serial link: default word width, counter sizing and bit order.
package shift_deser_pkg;

  localparam int unsigned DefaultWidth = 8;

  // Bit order agreed with the transmitter: first bit on the wire is the word MSB.
  localparam bit MsbFirst = 1'b1;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/deser_hold_reg.sv
// Single-entry valid/ready holding register; drops and flags words that arrive while full.
module deser_hold_reg
  import shift_deser_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  input  logic             i_ovr_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             w_free;

  // A word being drained this cycle frees the slot for a same-cycle load.
  assign w_free = !r_valid || i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (i_load && w_free) begin
        r_data  <= i_word;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end

      if (i_load && !w_free) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel receiver: shifts in one bit per strobe and hands full words to a holding
// register with valid/ready output.
module shift_deser
  import shift_deser_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  localparam int unsigned CNT_W = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_bit,
  input  logic             i_bit_en,
  input  logic             i_sync,
  input  logic             i_ready,
  input  logic             i_ovr_clr,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_sh_next;
  logic             w_complete;

  assign w_sh_next  = MsbFirst ? {r_sh[WIDTH-2:0], i_bit} : {i_bit, r_sh[WIDTH-1:1]};
  assign w_complete = i_bit_en && !i_sync && (r_cnt == LastCnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_sync) begin
      // A strobe coinciding with sync becomes the first bit of the realigned word.
      r_sh  <= i_bit_en ? {{(WIDTH-1){1'b0}}, i_bit} : '0;
      r_cnt <= i_bit_en ? CNT_W'(1) : '0;
    end else if (i_bit_en) begin
      r_sh  <= w_sh_next;
      r_cnt <= w_complete ? '0 : r_cnt + 1'b1;
    end
  end

  deser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_complete),
    .i_word   (w_sh_next),
    .i_ready  (i_ready),
    .i_ovr_clr(i_ovr_clr),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_overrun(o_overrun)
  );

  assign o_bit_cnt = r_cnt;

endmodule
